// File: rtl/time_pkg.sv
// Shared definitions for the time-set controller: field codes, time-word
// bit positions, field limits and FSM state encoding.
package time_pkg;

  localparam int TIME_W  = 17;
  localparam int MER_BIT = 16;
  localparam int HOUR_HI = 15;
  localparam int HOUR_LO = 12;
  localparam int MIN_HI  = 11;
  localparam int MIN_LO  = 6;
  localparam int SEC_HI  = 5;
  localparam int SEC_LO  = 0;

  localparam logic [5:0] HOUR_MAX   = 6'd11;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    FLD_NONE = 3'b000,
    FLD_HOUR = 3'b001,
    FLD_MIN  = 3'b010,
    FLD_SEC  = 3'b011,
    FLD_MER  = 3'b100
  } field_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EDIT = 2'b01,
    ST_LOAD = 2'b10
  } state_t;

  // Field selection order used by NEXT: hour -> min -> sec -> meridian -> hour
  function automatic field_t nextField(field_t f);
    case (f)
      FLD_HOUR: return FLD_MIN;
      FLD_MIN:  return FLD_SEC;
      FLD_SEC:  return FLD_MER;
      default:  return FLD_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key/time bus between the time-set controller and its surroundings.
interface time_set_ctrl_if;
  import time_pkg::*;

  logic              TICK;
  logic [TIME_W-1:0] CUR_TIME;
  logic              START;
  logic              NEXT;
  logic              UP;
  logic              DOWN;
  logic              COMMIT;
  logic              CANCEL;
  logic [TIME_W-1:0] EDIT_TIME;
  logic [2:0]        FIELD;
  logic              BUSY;
  logic              LOAD;
  logic              BLINK;

  modport master (
    output TICK, CUR_TIME, START, NEXT, UP, DOWN, COMMIT, CANCEL,
    input  EDIT_TIME, FIELD, BUSY, LOAD, BLINK
  );

  modport slave (
    input  TICK, CUR_TIME, START, NEXT, UP, DOWN, COMMIT, CANCEL,
    output EDIT_TIME, FIELD, BUSY, LOAD, BLINK
  );

endinterface

// File: rtl/time_field_step.sv
// Steps one time field by +1/-1 with wrap; out-of-range values snap to 0 (up) or max (down).
module time_field_step (
  input  logic [5:0] i_value,
  input  logic [5:0] i_max,
  input  logic       i_up,
  output logic [5:0] o_value
);

  always_comb begin
    if (i_up) begin
      o_value = (i_value >= i_max) ? 6'd0 : i_value + 6'd1;
    end else begin
      o_value = (i_value == 6'd0 || i_value > i_max) ? i_max : i_value - 6'd1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: edits a shadow copy of the live time and strobes LOAD
// on commit or after an idle timeout.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 1000,
  parameter int BLINK_TICKS   = 500
) (
  input logic           CLK,
  input logic           RESETN,
  time_set_ctrl_if.slave bus
);

  localparam int IDLE_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

  state_t              r_state;
  logic [TIME_W-1:0]   r_editTime;
  field_t              r_field;
  logic [IDLE_W-1:0]   r_idleCnt;
  logic [BLINK_W-1:0]  r_blinkCnt;
  logic                r_blink;

  state_t              w_nextState;
  logic [TIME_W-1:0]   w_editNext;
  field_t              w_fieldNext;
  logic [IDLE_W-1:0]   w_idleNext;
  logic [BLINK_W-1:0]  w_blinkCntNext;
  logic                w_blinkNext;
  logic                w_keyAct;
  logic                w_timeout;
  logic                w_blinkWrap;
  logic [5:0]          w_stepIn;
  logic [5:0]          w_stepMax;
  logic [5:0]          w_stepOut;

  assign w_keyAct    = bus.NEXT | bus.UP | bus.DOWN;
  // A key press in the same cycle as the final tick restarts the timeout instead
  assign w_timeout   = bus.TICK && !w_keyAct && (r_idleCnt == IDLE_W'(TIMEOUT_TICKS - 1));
  assign w_blinkWrap = (r_blinkCnt == BLINK_W'(BLINK_TICKS - 1));

  always_comb begin
    w_stepIn  = '0;
    w_stepMax = MINSEC_MAX;
    case (r_field)
      FLD_HOUR: begin
        w_stepIn  = {2'b00, r_editTime[HOUR_HI:HOUR_LO]};
        w_stepMax = HOUR_MAX;
      end
      FLD_MIN: w_stepIn = r_editTime[MIN_HI:MIN_LO];
      FLD_SEC: w_stepIn = r_editTime[SEC_HI:SEC_LO];
      default: ;
    endcase
  end

  time_field_step u_step (
    .i_value (w_stepIn),
    .i_max   (w_stepMax),
    .i_up    (bus.UP),
    .o_value (w_stepOut)
  );

  always_comb begin
    w_nextState    = r_state;
    w_editNext     = r_editTime;
    w_fieldNext    = r_field;
    w_idleNext     = r_idleCnt;
    w_blinkCntNext = r_blinkCnt;
    w_blinkNext    = r_blink;
    case (r_state)
      ST_IDLE: begin
        if (bus.START) begin
          w_nextState    = ST_EDIT;
          w_editNext     = bus.CUR_TIME;
          w_fieldNext    = FLD_HOUR;
          w_idleNext     = '0;
          w_blinkCntNext = '0;
          w_blinkNext    = 1'b1;
        end
      end
      ST_EDIT: begin
        if (bus.CANCEL) begin
          w_nextState    = ST_IDLE;
          w_fieldNext    = FLD_NONE;
          w_idleNext     = '0;
          w_blinkCntNext = '0;
          w_blinkNext    = 1'b0;
        end else if (bus.COMMIT || w_timeout) begin
          w_nextState    = ST_LOAD;
          w_idleNext     = '0;
          w_blinkCntNext = '0;
          w_blinkNext    = 1'b0;
        end else if (w_keyAct) begin
          w_idleNext     = '0;
          w_blinkCntNext = '0;
          w_blinkNext    = 1'b1;
          if (bus.NEXT) begin
            w_fieldNext = nextField(r_field);
          end else if (bus.UP != bus.DOWN) begin
            case (r_field)
              FLD_HOUR: w_editNext[HOUR_HI:HOUR_LO] = w_stepOut[3:0];
              FLD_MIN:  w_editNext[MIN_HI:MIN_LO]   = w_stepOut;
              FLD_SEC:  w_editNext[SEC_HI:SEC_LO]   = w_stepOut;
              FLD_MER:  w_editNext[MER_BIT]         = ~r_editTime[MER_BIT];
              default:  ;
            endcase
          end
        end else if (bus.TICK) begin
          w_idleNext = r_idleCnt + IDLE_W'(1);
          if (w_blinkWrap) begin
            w_blinkCntNext = '0;
            w_blinkNext    = ~r_blink;
          end else begin
            w_blinkCntNext = r_blinkCnt + BLINK_W'(1);
          end
        end
      end
      ST_LOAD: begin
        w_nextState = ST_IDLE;
        w_fieldNext = FLD_NONE;
      end
      default: begin
        w_nextState = ST_IDLE;
        w_fieldNext = FLD_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state    <= ST_IDLE;
      r_editTime <= '0;
      r_field    <= FLD_NONE;
      r_idleCnt  <= '0;
      r_blinkCnt <= '0;
      r_blink    <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_editTime <= w_editNext;
      r_field    <= w_fieldNext;
      r_idleCnt  <= w_idleNext;
      r_blinkCnt <= w_blinkCntNext;
      r_blink    <= w_blinkNext;
    end
  end

  assign bus.EDIT_TIME = r_editTime;
  assign bus.FIELD     = r_field;
  assign bus.BUSY      = (r_state != ST_IDLE);
  assign bus.LOAD      = (r_state == ST_LOAD);
  assign bus.BLINK     = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_time_set_ctrl;
  import time_pkg::*;

  localparam int TO = 1000;
  localparam int BL = 500;

  localparam logic [5:0] K_START  = 6'b100000;
  localparam logic [5:0] K_NEXT   = 6'b010000;
  localparam logic [5:0] K_UP     = 6'b001000;
  localparam logic [5:0] K_DOWN   = 6'b000100;
  localparam logic [5:0] K_COMMIT = 6'b000010;
  localparam logic [5:0] K_CANCEL = 6'b000001;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [16:0] curT = '0;

  time_set_ctrl_if busIf ();

  time_set_ctrl #(.TIMEOUT_TICKS(TO), .BLINK_TICKS(BL)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (busIf)
  );

  always #5 CLK = ~CLK;

  int nTests = 0;
  int nFail  = 0;
  int cycle  = 0;

  // Model state: session mode 0 idle / 1 editing / 2 loading, fields as plain integers
  int mMode = 0, mHour = 0, mMin = 0, mSec = 0, mMer = 0, mField = 0;
  int mIdleTicks = 0, mBlinkTicks = 0, mBlink = 0;

  function automatic int stepVal(int v, int maxv, bit up);
    if (up) return (v > maxv) ? 0 : (v + 1) % (maxv + 1);
    return (v == 0 || v > maxv) ? maxv : v - 1;
  endfunction

  function automatic logic [31:0] expTime();
    return 32'(mMer * 65536 + mHour * 4096 + mMin * 64 + mSec);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic modelStep(input logic rstn, input logic [5:0] k, input logic tk, input logic [16:0] cur);
    bit act;
    act = k[4] | k[3] | k[2];
    if (!rstn) begin
      mMode = 0; mHour = 0; mMin = 0; mSec = 0; mMer = 0; mField = 0;
      mIdleTicks = 0; mBlinkTicks = 0; mBlink = 0;
    end else if (mMode == 0) begin
      if (k[5]) begin
        mMode = 1; mField = 1; mIdleTicks = 0; mBlinkTicks = 0; mBlink = 1;
        mMer = int'(cur[16]); mHour = int'(cur[15:12]);
        mMin = int'(cur[11:6]); mSec = int'(cur[5:0]);
      end
    end else if (mMode == 1) begin
      if (k[0]) begin
        mMode = 0; mField = 0; mIdleTicks = 0; mBlinkTicks = 0; mBlink = 0;
      end else if (k[1] || (tk && !act && mIdleTicks + 1 == TO)) begin
        mMode = 2; mIdleTicks = 0; mBlinkTicks = 0; mBlink = 0;
      end else if (act) begin
        mIdleTicks = 0; mBlinkTicks = 0; mBlink = 1;
        if (k[4]) mField = mField % 4 + 1;
        else if (k[3] != k[2]) begin
          case (mField)
            1: mHour = stepVal(mHour, 11, k[3]);
            2: mMin  = stepVal(mMin, 59, k[3]);
            3: mSec  = stepVal(mSec, 59, k[3]);
            4: mMer  = 1 - mMer;
            default: ;
          endcase
        end
      end else if (tk) begin
        mIdleTicks++;
        mBlinkTicks++;
        if (mBlinkTicks == BL) begin
          mBlinkTicks = 0;
          mBlink = 1 - mBlink;
        end
      end
    end else begin
      mMode = 0; mField = 0;
    end
  endtask

  task automatic checkOutput();
    checkVal("busy",      32'(busIf.BUSY),      32'(mMode != 0));
    checkVal("load",      32'(busIf.LOAD),      32'(mMode == 2));
    checkVal("field",     32'(busIf.FIELD),     32'(mField));
    checkVal("edit_time", 32'(busIf.EDIT_TIME), expTime());
    checkVal("blink",     32'(busIf.BLINK),     32'(mBlink));
  endtask

  task automatic applyStimulus(input logic rstn, input logic [5:0] k, input logic tk, input logic [16:0] cur);
    @(negedge CLK);
    RESETN         = rstn;
    busIf.START    = k[5];
    busIf.NEXT     = k[4];
    busIf.UP       = k[3];
    busIf.DOWN     = k[2];
    busIf.COMMIT   = k[1];
    busIf.CANCEL   = k[0];
    busIf.TICK     = tk;
    busIf.CUR_TIME = cur;
    modelStep(rstn, k, tk, cur);
    @(posedge CLK);
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic step(input logic [5:0] k, input logic tk);
    applyStimulus(1'b1, k, tk, curT);
  endtask

  task automatic randomPhase(input int cycles, input int keyOdds, input int rstOdds);
    logic [5:0] k;
    for (int i = 0; i < cycles; i++) begin
      k    = '0;
      k[5] = ($urandom_range(1, 8) == 1);
      k[4] = ($urandom_range(1, keyOdds) == 1);
      k[3] = ($urandom_range(1, keyOdds) == 1);
      k[2] = ($urandom_range(1, keyOdds) == 1);
      k[1] = ($urandom_range(1, keyOdds * 4) == 1);
      k[0] = ($urandom_range(1, keyOdds * 4) == 1);
      curT = 17'($urandom_range(0, 131071));
      applyStimulus(($urandom_range(1, rstOdds) != 1), k, ($urandom_range(0, 3) != 0), curT);
    end
  endtask

  initial begin
    busIf.START = 0; busIf.NEXT = 0; busIf.UP = 0; busIf.DOWN = 0;
    busIf.COMMIT = 0; busIf.CANCEL = 0; busIf.TICK = 0; busIf.CUR_TIME = '0;

    applyStimulus(1'b0, '0, 1'b0, curT);
    applyStimulus(1'b0, '0, 1'b0, curT);
    checkVal("reset_busy",  32'(busIf.BUSY), 32'd0);
    checkVal("reset_time",  32'(busIf.EDIT_TIME), 32'd0);
    checkVal("reset_field", 32'(busIf.FIELD), 32'd0);
    checkVal("reset_blink", 32'(busIf.BLINK), 32'd0);

    // PM 11:59:58, hour up wraps to 0 and keeps PM
    curT = {1'b1, 4'd11, 6'd59, 6'd58};
    step(K_START, 1'b0);
    checkVal("start_busy",  32'(busIf.BUSY), 32'd1);
    checkVal("start_field", 32'(busIf.FIELD), 32'd1);
    step(K_UP, 1'b0);
    checkVal("hour_wrap", 32'(busIf.EDIT_TIME), 32'({1'b1, 4'd0, 6'd59, 6'd58}));
    curT = {1'b0, 4'd3, 6'd3, 6'd3};
    step(K_START, 1'b0);
    checkVal("start_ignored", 32'(busIf.EDIT_TIME), 32'({1'b1, 4'd0, 6'd59, 6'd58}));
    step(K_CANCEL, 1'b0);

    // Minute down wraps 0 -> 59, then commit timing
    curT = {1'b0, 4'd3, 6'd0, 6'd10};
    step(K_START, 1'b0);
    step(K_NEXT, 1'b0);
    step(K_DOWN, 1'b0);
    checkVal("min_wrap", 32'(busIf.EDIT_TIME[11:6]), 32'd59);
    step(K_COMMIT, 1'b0);
    checkVal("commit_load", 32'(busIf.LOAD), 32'd1);
    checkVal("commit_busy", 32'(busIf.BUSY), 32'd1);
    step('0, 1'b0);
    checkVal("commit_load_off", 32'(busIf.LOAD), 32'd0);
    checkVal("commit_idle",     32'(busIf.BUSY), 32'd0);
    checkVal("commit_field",    32'(busIf.FIELD), 32'd0);
    checkVal("commit_hold",     32'(busIf.EDIT_TIME), 32'({1'b0, 4'd3, 6'd59, 6'd10}));

    // Meridian field toggle, then cancel
    curT = {1'b0, 4'd5, 6'd20, 6'd30};
    step(K_START, 1'b0);
    step(K_NEXT, 1'b0);
    step(K_NEXT, 1'b0);
    step(K_NEXT, 1'b0);
    step(K_UP, 1'b0);
    checkVal("mer_field", 32'(busIf.FIELD), 32'd4);
    checkVal("mer_bit",   32'(busIf.EDIT_TIME[16]), 32'd1);
    step(K_CANCEL, 1'b0);
    checkVal("cancel_load",  32'(busIf.LOAD), 32'd0);
    checkVal("cancel_field", 32'(busIf.FIELD), 32'd0);
    checkVal("cancel_busy",  32'(busIf.BUSY), 32'd0);

    // Idle timeout after TO ticks, blink toggles after BL ticks
    step(K_START, 1'b0);
    checkVal("blink_entry", 32'(busIf.BLINK), 32'd1);
    for (int i = 1; i < TO; i++) begin
      step('0, 1'b1);
      if (i == BL) checkVal("blink_half", 32'(busIf.BLINK), 32'd0);
    end
    checkVal("no_early_load", 32'(busIf.LOAD), 32'd0);
    step('0, 1'b1);
    checkVal("timeout_load", 32'(busIf.LOAD), 32'd1);
    step('0, 1'b0);

    // Key on tick 999 restarts the timeout window
    step(K_START, 1'b0);
    for (int i = 1; i < TO - 1; i++) step('0, 1'b1);
    step(K_UP, 1'b1);
    for (int i = 1; i < TO; i++) step('0, 1'b1);
    checkVal("restart_no_load", 32'(busIf.LOAD), 32'd0);
    checkVal("restart_busy",    32'(busIf.BUSY), 32'd1);
    step('0, 1'b1);
    checkVal("restart_load", 32'(busIf.LOAD), 32'd1);
    step('0, 1'b0);

    // Cancel beats commit and up in the same cycle
    curT = {1'b0, 4'd7, 6'd30, 6'd15};
    step(K_START, 1'b0);
    step(K_UP, 1'b0);
    step(K_CANCEL | K_COMMIT | K_UP, 1'b0);
    checkVal("multi_busy", 32'(busIf.BUSY), 32'd0);
    checkVal("multi_load", 32'(busIf.LOAD), 32'd0);
    checkVal("multi_time", 32'(busIf.EDIT_TIME), 32'({1'b0, 4'd8, 6'd30, 6'd15}));

    // Reset on the commit edge suppresses the strobe
    step(K_START, 1'b0);
    applyStimulus(1'b0, K_COMMIT, 1'b0, curT);
    checkVal("rst_commit_load", 32'(busIf.LOAD), 32'd0);
    checkVal("rst_commit_time", 32'(busIf.EDIT_TIME), 32'd0);
    step('0, 1'b0);
    checkVal("rst_after_load", 32'(busIf.LOAD), 32'd0);

    randomPhase(4000, 8, 700);
    randomPhase(6000, 600, 3000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
